// File: rtl/ld_scoreboard_pkg.sv
// Shared sizing, bus-width helpers and the FIFO operation encoding for the load scoreboard.
// Build option LD_RESP_BYPASS_EN is consumed by ld_scoreboard.sv; nothing here depends on it.
package ld_scoreboard_pkg;

    localparam int LD_SB_MAX_OUTST = 2;
    localparam int LD_SB_AW        = 5;

    // Per-cycle tracker operation, encoded as {pop, push}.
    typedef enum logic [1:0] {
        SB_OP_IDLE = 2'b00,
        SB_OP_PUSH = 2'b01,
        SB_OP_POP  = 2'b10,
        SB_OP_BOTH = 2'b11
    } sbOpE;

    function automatic sbOpE sbOp(input logic push, input logic pop);
        return sbOpE'({pop, push});
    endfunction

    function automatic int esToSbBusWd(input int aw);
        return 1 + aw;
    endfunction

    function automatic int dsToSbBusWd(input int aw);
        return 2 * aw;
    endfunction

    function automatic int msToSbBusWd();
        return 1;
    endfunction

    function automatic bit isPow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ld_scoreboard_if.sv
// ID/EXE/MEM/WB-facing signal bundle of the load scoreboard.
// slave is the scoreboard's view, master is the pipeline's view.
interface ld_scoreboard_if
    import ld_scoreboard_pkg::*;
#(
    parameter int MAX_OUTST = LD_SB_MAX_OUTST,
    parameter int AW        = LD_SB_AW
)();

    localparam int CW = $clog2(MAX_OUTST) + 1;

    logic          ds_valid;
    logic [AW-1:0] ds_raddr1;
    logic [AW-1:0] ds_raddr2;
    logic          ds_stall;

    logic          es_ld_valid;
    logic [AW-1:0] es_ld_dest;
    logic          es_ld_ready;

    logic          ms_resp_valid;
    logic          wb_ld_valid;
    logic [AW-1:0] wb_ld_dest;

    logic          flush;
    logic [CW-1:0] outst_cnt;
    logic          err_underflow;

    modport slave (
        input  ds_valid, ds_raddr1, ds_raddr2,
        input  es_ld_valid, es_ld_dest,
        input  ms_resp_valid, flush,
        output ds_stall, es_ld_ready, wb_ld_valid, wb_ld_dest,
        output outst_cnt, err_underflow
    );

    modport master (
        output ds_valid, ds_raddr1, ds_raddr2,
        output es_ld_valid, es_ld_dest,
        output ms_resp_valid, flush,
        input  ds_stall, es_ld_ready, wb_ld_valid, wb_ld_dest,
        input  outst_cnt, err_underflow
    );

endinterface

// File: rtl/ld_sb_fifo.sv
// In-order circular tracker of outstanding loads: {live, dest} entries, wrap-bit pointers,
// a flush port that kills every live bit, and per-entry visibility for the pending decode.
module ld_sb_fifo
    import ld_scoreboard_pkg::*;
#(
    parameter  int MAX_OUTST = LD_SB_MAX_OUTST,
    parameter  int AW        = LD_SB_AW,
    localparam int PW        = $clog2(MAX_OUTST)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         push_live_i,
    input  logic [AW-1:0]                push_dest_i,
    input  logic                         pop_i,
    input  logic                         clear_live_i,
    input  logic                         hide_head_i,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [PW:0]                  count_o,
    output logic                         head_live_o,
    output logic [AW-1:0]                head_dest_o,
    output logic [MAX_OUTST-1:0]         live_vec_o,
    output logic [MAX_OUTST-1:0][AW-1:0] dest_vec_o
);

    logic [PW:0]                  headPtr_q, headPtr_d;
    logic [PW:0]                  tailPtr_q, tailPtr_d;
    logic [MAX_OUTST-1:0]         live_q, live_d;
    logic [MAX_OUTST-1:0][AW-1:0] dest_q, dest_d;
    logic [PW:0]                  count;
    logic [PW-1:0]                offset;
    sbOpE                         op;

    assign count   = tailPtr_q - headPtr_q;
    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == (PW+1)'(MAX_OUTST));
    assign op      = sbOp(push_i, pop_i);

    assign head_live_o = live_q[headPtr_q[PW-1:0]];
    assign head_dest_o = dest_q[headPtr_q[PW-1:0]];
    assign dest_vec_o  = dest_q;

    // A flush kills all live bits, but a load written in the same cycle takes push_live_i.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        live_d    = live_q;
        dest_d    = dest_q;
        case (op)
            SB_OP_PUSH: tailPtr_d = tailPtr_q + 1'b1;
            SB_OP_POP:  headPtr_d = headPtr_q + 1'b1;
            SB_OP_BOTH: begin
                headPtr_d = headPtr_q + 1'b1;
                tailPtr_d = tailPtr_q + 1'b1;
            end
            default: ;
        endcase
        if (clear_live_i) begin
            live_d = '0;
        end
        if (push_i) begin
            live_d[tailPtr_q[PW-1:0]] = push_live_i;
            dest_d[tailPtr_q[PW-1:0]] = push_dest_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            live_q    <= '0;
            dest_q    <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            live_q    <= live_d;
            dest_q    <= dest_d;
        end
    end

    // An entry is visible when occupied, live, and not the head being hidden for bypass.
    always_comb begin
        offset     = '0;
        live_vec_o = '0;
        for (int i = 0; i < MAX_OUTST; i++) begin
            offset        = PW'(i) - headPtr_q[PW-1:0];
            live_vec_o[i] = ({1'b0, offset} < count) && live_q[i]
                            && !(hide_head_i && (offset == '0));
        end
    end

endmodule

// File: rtl/ld_scoreboard.sv
// Load scoreboard and issue gate: tracks loads from EXE until MEM responds, stalls ID on load-use.
// Define LD_RESP_BYPASS_EN to let a dependent instruction issue in its producer's response cycle.
module ld_scoreboard
    import ld_scoreboard_pkg::*;
#(
    parameter int MAX_OUTST = LD_SB_MAX_OUTST,
    parameter int AW        = LD_SB_AW
)(
    input  logic            clk,
    input  logic            reset,
    ld_scoreboard_if.slave  sb
);

    localparam int PW        = $clog2(MAX_OUTST);
    localparam int ES_BUS_WD = esToSbBusWd(AW);
    localparam int DS_BUS_WD = dsToSbBusWd(AW);
    localparam int MS_BUS_WD = msToSbBusWd();

    logic [ES_BUS_WD-1:0]         esBus;
    logic [DS_BUS_WD-1:0]         dsBus;
    logic [MS_BUS_WD-1:0]         msBus;
    logic                         ldValid;
    logic [AW-1:0]                ldDest;
    logic [AW-1:0]                rAddr1;
    logic [AW-1:0]                rAddr2;
    logic                         respValid;

    logic                         push;
    logic                         pop;
    logic                         ready;
    logic                         hideHead;
    logic                         empty;
    logic                         full;
    logic [PW:0]                  count;
    logic                         headLive;
    logic [AW-1:0]                headDest;
    logic [MAX_OUTST-1:0]         liveVec;
    logic [MAX_OUTST-1:0][AW-1:0] destVec;
    logic                         hit1;
    logic                         hit2;
    logic                         errUnderflow_q, errUnderflow_d;

    assign esBus     = {sb.es_ld_valid, sb.es_ld_dest};
    assign dsBus     = {sb.ds_raddr1, sb.ds_raddr2};
    assign msBus     = sb.ms_resp_valid;
    assign ldValid   = esBus[AW];
    assign ldDest    = esBus[AW-1:0];
    assign rAddr1    = dsBus[DS_BUS_WD-1:AW];
    assign rAddr2    = dsBus[AW-1:0];
    assign respValid = msBus[0];

    // A full tracker still accepts a load when the head pops in the same cycle.
    assign ready = !full || respValid;
    assign push  = ldValid && ready;
    assign pop   = respValid && !empty;

`ifdef LD_RESP_BYPASS_EN
    assign hideHead = pop;
`else
    assign hideHead = 1'b0;
`endif

    ld_sb_fifo #(
        .MAX_OUTST (MAX_OUTST),
        .AW        (AW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_live_i  (!sb.flush),
        .push_dest_i  (ldDest),
        .pop_i        (pop),
        .clear_live_i (sb.flush),
        .hide_head_i  (hideHead),
        .empty_o      (empty),
        .full_o       (full),
        .count_o      (count),
        .head_live_o  (headLive),
        .head_dest_o  (headDest),
        .live_vec_o   (liveVec),
        .dest_vec_o   (destVec)
    );

    // r0 is never pending, even though loads to it hold a slot to keep response order.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (liveVec[i] && (destVec[i] == rAddr1) && (rAddr1 != '0)) begin
                hit1 = 1'b1;
            end
            if (liveVec[i] && (destVec[i] == rAddr2) && (rAddr2 != '0)) begin
                hit2 = 1'b1;
            end
        end
    end

    assign errUnderflow_d = errUnderflow_q || (respValid && empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errUnderflow_q <= 1'b0;
        end else begin
            errUnderflow_q <= errUnderflow_d;
        end
    end

    assign sb.ds_stall      = sb.ds_valid && (hit1 || hit2);
    assign sb.es_ld_ready   = ready;
    assign sb.wb_ld_valid   = pop && headLive && (headDest != '0);
    assign sb.wb_ld_dest    = headDest;
    assign sb.outst_cnt     = count;
    assign sb.err_underflow = errUnderflow_q;

    // Issuing a load without ready is a pipeline bug; the load has already been dropped above.
    ldIssueWhileFull : assert property (@(posedge clk) disable iff (reset) ldValid |-> ready);

endmodule

// File: tb/tb_ld_scoreboard.sv
// Self-checking bench for ld_scoreboard: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of outstanding loads.
module tb_ld_scoreboard;
   import ld_scoreboard_pkg::*;

   localparam int MAXO = 2;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bit            mLive[$];
   logic [AW-1:0] mDest[$];
   bit            mErr;

   ld_scoreboard_if #(.MAX_OUTST(MAXO), .AW(AW)) sbIf();

   ld_scoreboard #(.MAX_OUTST(MAXO), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sbIf)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Single comparison point shared by all checks.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A register is pending if some live outstanding load targets it (r0 never).
   function automatic bit pendingOf(input logic [AW-1:0] r, input bit skipHead);
      if (r == '0) return 1'b0;
      for (int k = (skipHead ? 1 : 0); k < mLive.size(); k++) begin
         if (mLive[k] && mDest[k] == r) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit modelReady();
      return (mLive.size() < MAXO) || sbIf.ms_resp_valid;
   endfunction

   task automatic applyStimulus(input bit dsV, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input bit ldV, input logic [AW-1:0] ld, input bit resp, input bit fl);
      sbIf.ds_valid      = dsV;
      sbIf.ds_raddr1     = a1;
      sbIf.ds_raddr2     = a2;
      sbIf.es_ld_valid   = ldV;
      sbIf.es_ld_dest    = ld;
      sbIf.ms_resp_valid = resp;
      sbIf.flush         = fl;
   endtask

   // Compares every DUT output with what the model predicts for the current inputs.
   task automatic checkOutput();
      bit popping;
      bit skip;
      bit expStall;
      bit expWb;
      popping = sbIf.ms_resp_valid && (mLive.size() > 0);
`ifdef LD_RESP_BYPASS_EN
      skip = popping;
`else
      skip = 1'b0;
`endif
      expStall = sbIf.ds_valid && (pendingOf(sbIf.ds_raddr1, skip) || pendingOf(sbIf.ds_raddr2, skip));
      expWb    = popping && mLive[0] && (mDest[0] != '0);
      chk("ready", 32'(sbIf.es_ld_ready), 32'(modelReady()));
      chk("stall", 32'(sbIf.ds_stall), 32'(expStall));
      chk("wb_valid", 32'(sbIf.wb_ld_valid), 32'(expWb));
      if (mLive.size() > 0) chk("wb_dest", 32'(sbIf.wb_ld_dest), 32'(mDest[0]));
      chk("outst_cnt", 32'(sbIf.outst_cnt), 32'(mLive.size()));
      chk("err_underflow", 32'(sbIf.err_underflow), 32'(mErr));
   endtask

   // Advances one clock and applies the tracker rules to the model.
   task automatic tick();
      bit rdy;
      rdy = modelReady();
      @(posedge clk);
      if (sbIf.ms_resp_valid) begin
         if (mLive.size() > 0) begin
            void'(mLive.pop_front());
            void'(mDest.pop_front());
         end else begin
            mErr = 1'b1;
         end
      end
      if (sbIf.flush) begin
         foreach (mLive[k]) mLive[k] = 1'b0;
      end
      if (sbIf.es_ld_valid && rdy) begin
         mLive.push_back(!sbIf.flush);
         mDest.push_back(sbIf.es_ld_dest);
      end
      @(negedge clk);
   endtask

   task automatic cycle(input bit dsV, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit ldV, input logic [AW-1:0] ld, input bit resp, input bit fl);
      applyStimulus(dsV, a1, a2, ldV, ld, resp, fl);
      #1 checkOutput();
      tick();
   endtask

   task automatic applyReset(input int n);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mLive.delete();
      mDest.delete();
      mErr = 1'b0;
      #1 checkOutput();
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit            dsV, ldV, resp, fl;
      logic [AW-1:0] a1, a2, ld;

      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mErr = 1'b0;
      @(negedge clk);

      // Reset held for three cycles, then idle with a valid ID instruction.
      applyReset(3);
      applyStimulus(1, 5, 6, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t1_cnt", 32'(sbIf.outst_cnt), 0);
      chk("t1_ready", 32'(sbIf.es_ld_ready), 1);
      chk("t1_stall", 32'(sbIf.ds_stall), 0);
      tick();

      // Load-use on r5 with the response arriving at T3.
      cycle(0, 0, 0, 1, 5, 0, 0);
      for (int t = 1; t <= 2; t++) begin
         applyStimulus(1, 5, 0, 0, 0, 0, 0);
         #1 checkOutput();
         chk("t2_stall_wait", 32'(sbIf.ds_stall), 1);
         tick();
      end
      applyStimulus(1, 5, 0, 0, 0, 1, 0);
      #1 checkOutput();
`ifdef LD_RESP_BYPASS_EN
      chk("t2_stall_resp", 32'(sbIf.ds_stall), 0);
`else
      chk("t2_stall_resp", 32'(sbIf.ds_stall), 1);
`endif
      chk("t2_wb_valid", 32'(sbIf.wb_ld_valid), 1);
      chk("t2_wb_dest", 32'(sbIf.wb_ld_dest), 5);
      tick();
      applyStimulus(1, 5, 0, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t2_stall_after", 32'(sbIf.ds_stall), 0);
      tick();

      // Fill with r3, r4, then pop r3 and push r6 in the same cycle.
      cycle(0, 0, 0, 1, 3, 0, 0);
      cycle(1, 3, 4, 1, 4, 0, 0);
      applyStimulus(1, 4, 3, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t3_full_ready", 32'(sbIf.es_ld_ready), 0);
      chk("t3_full_cnt", 32'(sbIf.outst_cnt), 2);
      tick();
      applyStimulus(0, 0, 0, 1, 6, 1, 0);
      #1 checkOutput();
      chk("t3_swap_ready", 32'(sbIf.es_ld_ready), 1);
      chk("t3_swap_dest", 32'(sbIf.wb_ld_dest), 3);
      tick();
      applyStimulus(1, 6, 3, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t3_swap_cnt", 32'(sbIf.outst_cnt), 2);
      chk("t3_r6_stall", 32'(sbIf.ds_stall), 1);
      tick();
      cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 1, 0);

      // Flush with r7, r8 outstanding; responses must be absorbed silently.
      cycle(0, 0, 0, 1, 7, 0, 0);
      cycle(0, 0, 0, 1, 8, 0, 0);
      cycle(1, 7, 8, 0, 0, 0, 1);
      applyStimulus(1, 7, 8, 0, 0, 1, 0);
      #1 checkOutput();
      chk("t4_stall_r7r8", 32'(sbIf.ds_stall), 0);
      chk("t4_wb0", 32'(sbIf.wb_ld_valid), 0);
      chk("t4_cnt2", 32'(sbIf.outst_cnt), 2);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      #1 checkOutput();
      chk("t4_wb1", 32'(sbIf.wb_ld_valid), 0);
      chk("t4_cnt1", 32'(sbIf.outst_cnt), 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t4_cnt0", 32'(sbIf.outst_cnt), 0);
      tick();

      // Response with the tracker empty: sticky underflow flag.
      cycle(0, 0, 0, 0, 0, 1, 0);
      for (int t = 0; t < 3; t++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
         #1 checkOutput();
         chk("t5_err_sticky", 32'(sbIf.err_underflow), 1);
         chk("t5_cnt", 32'(sbIf.outst_cnt), 0);
         tick();
      end

      // Load to r0 holds a slot but never stalls or writes back.
      cycle(0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t6_stall_r0", 32'(sbIf.ds_stall), 0);
      chk("t6_cnt1", 32'(sbIf.outst_cnt), 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      #1 checkOutput();
      chk("t6_wb_r0", 32'(sbIf.wb_ld_valid), 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput();
      chk("t6_cnt0", 32'(sbIf.outst_cnt), 0);
      tick();

      // Reset in the middle of traffic discards entries and clears the sticky flag.
      cycle(0, 0, 0, 1, 9, 0, 0);
      applyReset(2);
      chk("rst_err", 32'(sbIf.err_underflow), 0);
      chk("rst_cnt", 32'(sbIf.outst_cnt), 0);

      // Random traffic over a small register set so hazards are frequent.
      for (int n = 0; n < 600; n++) begin
         dsV  = ($urandom_range(0, 3) != 0);
         a1   = AW'($urandom_range(0, 7));
         a2   = AW'($urandom_range(0, 7));
         ld   = AW'($urandom_range(0, 7));
         resp = (mLive.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
         fl   = ($urandom_range(0, 19) == 0);
         ldV  = ($urandom_range(0, 2) != 0) && ((mLive.size() < MAXO) || resp);
         cycle(dsV, a1, a2, ldV, ld, resp, fl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
